// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - shared state type for the down-counter timer
//
// Purpose: FSM state encoding used by down_counter_timer.
// Contents: STATE_W (state register width), state_t {IDLE, RUN, DONE}.
package down_counter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_prescaler.sv
// rtl/down_counter_prescaler.sv - count-enable prescaler for the down-counter timer
//
// Purpose: emits a one-cycle tick on every PRE-th cycle in which en is high.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   clr  - synchronous clear of the divide count
//   en   - only cycles with en=1 advance the divide count
//   tick - high in the cycle that completes a group of PRE enabled cycles
module down_counter_prescaler #(
    parameter int PRE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(PRE + 1);

    logic [CW-1:0] cnt;

    // Combinational so the consuming edge sees the tick in the same cycle
    // as the enabled cycle that completes the group.
    assign tick = en && (cnt == CW'(PRE - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counter / interval timer
//
// Purpose: loads a start value, counts to zero under en, then stops (DONE)
// or reloads and keeps running; emits a one-cycle terminal-count pulse.
// Optional feature macro: DOWN_COUNTER_PRESCALE_EN (count only on every
// PRE-th enabled cycle).
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   load        - capture load_val into q and the reload register, go IDLE
//   load_val    - N-bit load value
//   start       - begin/resume counting (IDLE) or restart from reload (DONE)
//   stop        - abort counting, hold q, go IDLE
//   en          - count enable
//   auto_reload - 1: reload at zero and keep running; 0: one-shot
//   q           - current count (registered)
//   tc          - terminal-count pulse, high in the first cycle q reads 0
//   busy        - high in RUN (registered)
//   done        - high in DONE (registered)
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int N   = 4,
    parameter int PRE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         en,
    input  logic         auto_reload,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    state_t       state;
    state_t       state_n;
    logic [N-1:0] reload_reg;
    logic [N-1:0] reload_n;
    logic [N-1:0] q_n;
    logic         tc_n;
    logic         tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
    down_counter_prescaler #(
        .PRE (PRE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load | start | stop),
        .en   (en),
        .tick (tick)
    );
`else
    logic unused_pre;

    assign tick       = 1'b1;
    assign unused_pre = ^PRE;
`endif

    always_comb begin
        state_n  = state;
        q_n      = q;
        reload_n = reload_reg;
        tc_n     = 1'b0;

        if (load) begin
            q_n      = load_val;
            reload_n = load_val;
            state_n  = IDLE;
        end else if (stop) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (q != '0)) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (q == '0) begin
                        // Zero is held for one tick before reloading or
                        // finishing, so the auto-reload period is reload+1.
                        if (tick) begin
                            if (auto_reload) begin
                                q_n = reload_reg;
                            end else begin
                                state_n = DONE;
                            end
                        end
                    end else if (en && tick) begin
                        q_n  = q - N'(1);
                        tc_n = (q == N'(1));
                    end
                end
                DONE: begin
                    if (start && (reload_reg != '0)) begin
                        q_n     = reload_reg;
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            q          <= q_n;
            reload_reg <= reload_n;
            tc         <= tc_n;
            busy       <= (state_n == RUN);
            done       <= (state_n == DONE);
        end
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Synchronous, loadable N-bit down-counter/timer. It is the counting-down counterpart to the team's synchronous up counter.
- Loads a start value and counts to zero under enable, then either stops or auto-reloads.
- Emits a one-cycle terminal-count pulse.
- Used as a programmable interval timer and a delay/timeout source beside the up-counters in the sequential library.

Parameters:
N, 4, counter width in bits
PRE, 4, prescale divide ratio; used only when DOWN_COUNTER_PRESCALE_EN is defined; legal range 1..2^16-1

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-high
load  input  1  pulse; capture load_val into q and reload_reg
load_val  input  N  value to load
start  input  1  pulse; begin or resume counting
stop  input  1  pulse; abort counting and hold q
en  input  1  count enable; when low, counting pauses
auto_reload  input  1  1 = reload and continue at zero; 0 = one-shot
q  output  N  current count (registered)
tc  output  1  terminal-count pulse (registered)
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (rst=1 at an edge): q=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0. Reset overrides every other input, including mid-count.
- Priority per edge: rst > load > stop > start > counting.
- States: IDLE, RUN, DONE. Outputs are registered: busy=(state==RUN), done=(state==DONE).
- load, in any state:
  - q<=load_val and reload_reg<=load_val.
  - state<=IDLE, tc<=0.
  - A start in the same cycle is ignored.
- IDLE:
  - start with q!=0 -> RUN; q is unchanged on that edge.
  - start with q==0 is ignored; state stays IDLE.
- RUN, with en=1 and q!=0:
  - q<=q-1.
  - tc<=1 exactly when q==1, so tc is high during the first cycle q reads 0.
- RUN, with en=0: q and state hold, tc<=0.
- RUN, with q==0 (next edge, regardless of en):
  - auto_reload=1: q<=reload_reg and stay in RUN. The steady period is reload_reg+1 cycles with en held high.
  - auto_reload=0: state<=DONE, q holds 0.
- RUN, stop: state<=IDLE, q holds its current value, tc<=0. A later start resumes from the held q.
- DONE:
  - q holds 0.
  - start with reload_reg!=0 -> q<=reload_reg and state<=RUN.
  - start with reload_reg==0 is ignored.
  - stop -> IDLE.
- tc is 0 in every cycle except the pulse defined above. It is never asserted in IDLE or DONE.
- q never wraps: no decrement below 0. All arithmetic is N-bit unsigned.
- Latency: start at edge t -> busy=1 after t. First decrement at the next enabled edge. Load value L (L>0) gives q==0 at L enabled edges after RUN entry.

Optional Feature:
DOWN_COUNTER_PRESCALE_EN
- Defined:
  - An internal prescaler produces a tick every PRE cycles in which en=1.
  - Decrements and the tc condition require en&&tick.
  - The prescaler clears on rst, load, start and stop.
  - The q==0 reload/DONE transition also waits for a tick.
- Undefined: tick is constant 1 and the behaviour is exactly as above. PRE is unused.

Decomposition:
- Package down_counter_pkg:
  - typedef enum state_t {IDLE, RUN, DONE}.
  - Localparam for state encoding width.
- Sub-module down_counter_prescaler (clk, rst, clr, en -> tick):
  - Instantiated only under DOWN_COUNTER_PRESCALE_EN.
  - Its counter width is $clog2(PRE+1).
- The top holds the FSM, q, reload_reg and tc.

Test Plan (N=4, macro undefined unless stated):
- Hold rst for 2 cycles with load=1, start=1 -> q=0, tc=0, busy=0, done=0; both inputs are ignored.
- load_val=5 load, then start, en=1, auto_reload=0 -> q reads 5,5,4,3,2,1,0. tc is high only in the first q=0 cycle. done=1 one cycle later, busy=0, and q stays 0.
- load 3, auto_reload=1, start -> q cycles 3,2,1,0,3,2,1,0. tc pulses every 4 cycles and busy stays 1.
- load 6, start; drop en for 2 cycles at q=4, then stop at q=2, then start -> q holds 4 for 2 cycles; q holds 2 in IDLE; counting resumes 2,1,0.
- Corner cases:
  - start with q=0 stays in IDLE.
  - load 15 together with start mid-RUN gives IDLE with q=15.
  - rst mid-RUN gives all outputs 0 on the next cycle.
- DOWN_COUNTER_PRESCALE_EN defined, PRE=3, load 2, start, en=1 -> q steps once every 3 cycles. tc coincides with the first q=0 cycle.
